// File: rtl/egg_timer_bank.sv
// Bank of independent countdown timers with optional auto-reload, per-channel
// cancel and a one-cycle start pulse after synchronous reset.
module egg_timer_bank #(
  parameter int CHANNELS = 4,
  parameter int TIMER_W  = 7,
  parameter int CH_W     = 2
) (
  input  logic                sysclk,
  input  logic                reset,
  output logic                selection,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CH_W-1:0]     load_chan,
  input  logic [TIMER_W-1:0]  load_value,
  input  logic [CHANNELS-1:0] cancel,
  input  logic [CHANNELS-1:0] reload_en,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] expire,
  input  logic [CH_W-1:0]     rd_chan,
  output logic [TIMER_W-1:0]  rd_count
);

  logic                r_selection;
  logic [CHANNELS-1:0] r_busy;
  logic [CHANNELS-1:0] r_expire;
  logic [TIMER_W-1:0]  r_count  [CHANNELS];
  logic [TIMER_W-1:0]  r_reload [CHANNELS];

  logic [CHANNELS-1:0] w_load_hit;
  logic [CHANNELS-1:0] w_expiring;
  logic [TIMER_W-1:0]  w_load_start;

  // A zero start value counts as one so every load produces an expiry.
  function automatic logic [TIMER_W-1:0] at_least_one(input logic [TIMER_W-1:0] v);
    return (v == '0) ? TIMER_W'(1) : v;
  endfunction

  assign selection    = r_selection;
  assign load_ready   = ~r_selection;
  assign busy         = r_busy;
  assign expire       = r_expire;
  assign w_load_start = at_least_one(load_value);

  // NOTE: every bit gets a default before the loop, otherwise the
  // conditional assignments below would infer latches.
  always_comb begin
    w_load_hit = '0;
    w_expiring = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (load_valid && load_ready && (int'(load_chan) == c))
        w_load_hit[c] = 1'b1;
      w_expiring[c] = r_busy[c] && (r_count[c] == TIMER_W'(1)) &&
                      !w_load_hit[c] && !cancel[c];
    end
  end

  always_comb begin
    rd_count = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (int'(rd_chan) == c) rd_count = r_count[c];
  end

  // NOTE: state uses non-blocking assignments so every channel updates from
  // the same pre-edge values. The count and reload arrays are reset here
  // because an aborted countdown must not survive reset.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_selection <= 1'b1;
      r_busy      <= '0;
      r_expire    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_count[c]  <= '0;
        r_reload[c] <= '0;
      end
    end else begin
      r_selection <= 1'b0;
      r_expire    <= w_expiring;
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_load_hit[c]) begin
          r_count[c]  <= w_load_start;
          r_reload[c] <= load_value;
          r_busy[c]   <= 1'b1;
        end else if (cancel[c]) begin
          r_count[c] <= '0;
          r_busy[c]  <= 1'b0;
        end else if (w_expiring[c]) begin
          if (reload_en[c]) begin
            r_count[c] <= at_least_one(r_reload[c]);
          end else begin
            r_count[c] <= '0;
            r_busy[c]  <= 1'b0;
          end
        end else if (r_busy[c]) begin
          r_count[c] <= r_count[c] - TIMER_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/egg_timer_bank.md
EGG_TIMER_BANK -- requirements
Module: egg_timer_bank

Interface
REQ-001 Parameter CHANNELS, default 4, SHALL set the number of independent countdown channels (legal range 1..16).
REQ-002 Parameter TIMER_W, default 7, SHALL set the counter and load-value width in bits (legal range 2..32).
REQ-003 Parameter CH_W, default 2, SHALL set the channel-index width, equal to max(1, ceil(log2(CHANNELS))).
REQ-004 sysclk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-low reset, sampled on the sysclk rising edge.
REQ-006 selection  out  1  SHALL be the post-reset one-cycle start pulse.
REQ-007 load_valid  in  1  SHALL request a load of load_value into channel load_chan.
REQ-008 load_ready  out  1  SHALL indicate that the bank accepts a load this cycle.
REQ-009 load_chan  in  CH_W  SHALL select the target channel of a load.
REQ-010 load_value  in  TIMER_W  SHALL carry the countdown start value.
REQ-011 cancel  in  CHANNELS  SHALL be a per-channel stop bitmask.
REQ-012 reload_en  in  CHANNELS  SHALL be a per-channel auto-reload mode enable.
REQ-013 busy  out  CHANNELS  SHALL flag channels that are currently counting.
REQ-014 expire  out  CHANNELS  SHALL carry a per-channel one-cycle expiry pulse.
REQ-015 rd_chan  in  CH_W  SHALL select the channel observed on rd_count.
REQ-016 rd_count  out  TIMER_W  SHALL be the combinational current count of channel rd_chan.

Function
REQ-017 selection SHALL be 1 after every edge that samples reset=0, and 0 after every edge that samples reset=1; it is therefore high for exactly one cycle after reset release.
REQ-018 load_ready SHALL equal NOT selection.
REQ-019 A load SHALL be accepted only on an edge with load_valid=1 and load_ready=1; load_chan >= CHANNELS SHALL be ignored with no state change.
REQ-020 An accepted load of V SHALL set count=max(V,1), busy=1 and store V as that channel's reload value; the load takes effect on the accepting edge.
REQ-021 A busy channel SHALL decrement its count by 1 on every edge that has no load or cancel for that channel.
REQ-022 Expiry SHALL occur on an edge where a busy channel holds count=1 and has no load or cancel: expire is 1 for the following cycle only; V cycles separate the load edge and the expire cycle (V=0 behaves as V=1).
REQ-023 On expiry with reload_en=0, the channel SHALL go to count=0, busy=0.
REQ-024 On expiry with reload_en=1, the channel SHALL set count=max(stored value,1), keep busy=1, and pulse expire periodically.
REQ-025 cancel[c]=1 SHALL set count=0 and busy=0 on that edge, with no expire pulse.
REQ-026 Load and cancel of the same channel on the same edge: load SHALL win.
REQ-027 Load or cancel on the edge where count=1 SHALL suppress that expire pulse.
REQ-028 A load to a busy channel SHALL restart it with the new value.
REQ-029 Channels SHALL be fully independent; simultaneous expiries on several channels SHALL all pulse in the same cycle.
REQ-030 rd_count SHALL read 0 for rd_chan >= CHANNELS.
REQ-031 Counts SHALL never wrap below 0; an idle channel holds 0.

Reset
REQ-032 On an edge that samples reset=0: all counts, stored reload values, busy and expire SHALL be cleared to 0, and selection SHALL be set to 1, regardless of any in-flight countdown or load.
REQ-033 A load presented on the reset edge or during the selection cycle SHALL be ignored.

Verification
REQ-034 Release reset -> selection=1 and load_ready=0 for exactly one cycle, then selection=0 and load_ready=1; all other outputs 0.
REQ-035 Load ch1 V=5, reload_en=0 -> busy[1]=1, rd_count steps 5,4,3,2,1, expire[1] high 5 cycles after the load edge for 1 cycle, then busy[1]=0.
REQ-036 Load ch0 V=3 with reload_en[0]=1 -> expire[0] pulses every 3 cycles; clear reload_en -> the next expiry is the last one and busy[0] drops.
REQ-037 Load ch2 V=4; assert cancel[2] on the count=1 edge -> no expire pulse, busy[2]=0; then load ch2 with cancel[2]=1 on the same edge -> load wins, count=load value.
REQ-038 Load ch3 V=0 -> expire[3] is high the cycle after the load edge; load V=127 (TIMER_W=7) -> expire after 127 cycles with no wrap.
REQ-039 Apply reset while ch0 and ch1 are counting -> counts and busy clear, no expire is generated, and selection pulses after release.
